// File: rtl/zx_pixel_fetch.sv
// ZX Spectrum screen fetcher with ping-pong line buffer and 2x RGB444 renderer.
// Define ZX_FLASH_EN to build the frame counter and attribute flash swap.
module zx_pixel_fetch #(
    parameter logic [15:0] BASE     = 16'h4000,
    parameter int          V_TOTAL  = 525,
    parameter int          ACTIVE_W = 512,
    parameter int          ACTIVE_H = 384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic [2:0]  border,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        underrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BMP  = 2'd1,
        ATTR = 2'd2
    } state_t;

    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FILL  = 10'd382;
    localparam logic [9:0] W_PAPER = 10'(ACTIVE_W);
    localparam logic [9:0] H_PAPER = 10'(ACTIVE_H);
    localparam logic [15:0] ATTR_BASE = BASE + 16'd6144;

    state_t     state;
    state_t     state_nx;
    logic [4:0] col;
    logic [4:0] col_nx;
    logic [7:0] row;
    logic [7:0] row_nx;
    logic       gap;
    logic       gap_nx;
    logic       underrun_nx;
    logic       wr_en;

    logic       trig_top;
    logic       trig_row;
    logic       trigger;
    logic [7:0] trig_sel;

    logic [7:0] bmp_buf  [64];
    logic [7:0] attr_buf [64];

    // Row r+1 is fetched while row r is on its second VGA line.
    assign trig_top = pix_en && (hpos == 10'd0) && (vpos == V_LAST);
    assign trig_row = pix_en && (hpos == 10'd0) && vpos[0] && (vpos < V_FILL);
    assign trigger  = trig_top || trig_row;
    assign trig_sel = trig_top ? 8'd0 : vpos[8:1] + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            col      <= 5'd0;
            row      <= 8'd0;
            gap      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            row      <= row_nx;
            gap      <= gap_nx;
            underrun <= underrun_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        col_nx      = col;
        row_nx      = row;
        gap_nx      = gap;
        underrun_nx = underrun;
        wr_en       = 1'b0;
        if (trigger) begin
            if (state != IDLE) begin
                underrun_nx = 1'b1;
            end
            state_nx = BMP;
            col_nx   = 5'd0;
            row_nx   = trig_sel;
            gap_nx   = 1'b1;
        end else if (state != IDLE) begin
            if (gap) begin
                gap_nx = 1'b0;
            end else if (mem_ack) begin
                wr_en  = 1'b1;
                gap_nx = 1'b1;
                unique case (state)
                    BMP: state_nx = ATTR;
                    ATTR: begin
                        if (col == 5'd31) begin
                            state_nx = IDLE;
                        end else begin
                            state_nx = BMP;
                            col_nx   = col + 5'd1;
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    // The gap cycle after every ack forces mem_req low between requests.
    always_comb begin
        mem_req  = (state != IDLE) && !gap;
        mem_addr = 16'd0;
        unique case (state)
            BMP:  mem_addr = BASE + 16'({row[7:6], row[2:0], row[5:3], col});
            ATTR: mem_addr = ATTR_BASE + 16'({row[7:3], col});
            default: mem_addr = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (state == BMP) begin
                bmp_buf[{row[0], col}] <= mem_data;
            end else begin
                attr_buf[{row[0], col}] <= mem_data;
            end
        end
    end

    logic       paper_area;
    logic [5:0] rd_idx;
    logic [7:0] bmp_byte;
    logic [7:0] attr_byte;
    logic       pix;
    logic       flash_swap;
    logic [2:0] colour;
    logic       bright;

    assign paper_area = (hpos < W_PAPER) && (vpos < H_PAPER);
    assign rd_idx     = {vpos[1], hpos[8:4]};
    assign bmp_byte   = bmp_buf[rd_idx];
    assign attr_byte  = attr_buf[rd_idx];
    assign pix        = bmp_byte[~hpos[3:1]];

`ifdef ZX_FLASH_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 5'd0;
        end else if (pix_en && (hpos == 10'd0) && (vpos == 10'd0)) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign flash_swap = attr_byte[7] & frame_cnt[4];
`else
    logic unused_flash;

    assign unused_flash = attr_byte[7];
    assign flash_swap   = 1'b0;
`endif

    always_comb begin
        colour = 3'd0;
        bright = 1'b0;
        if (display_on) begin
            if (paper_area) begin
                colour = (pix ^ flash_swap) ? attr_byte[2:0] : attr_byte[5:3];
                bright = attr_byte[6];
            end else begin
                colour = border;
            end
        end
    end

    function automatic logic [3:0] chan(input logic on, input logic br);
        return on ? (br ? 4'hF : 4'hA) : 4'h0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
        end else if (pix_en) begin
            red   <= chan(colour[1], bright);
            green <= chan(colour[2], bright);
            blue  <= chan(colour[0], bright);
        end
    end

endmodule

// File: tb/tb_zx_pixel_fetch.sv
// Directed bench for zx_pixel_fetch: fetch order, overrun, reset and rendering.
module tb_zx_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_on;
    logic [2:0]  border;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        underrun;

    int checks = 0;
    int errors = 0;

`ifdef ZX_FLASH_EN
    localparam logic [7:0] ATTR0 = 8'hC7;
`else
    localparam logic [7:0] ATTR0 = 8'h47;
`endif

    zx_pixel_fetch dut (
        .clk(clk),
        .reset(reset),
        .pix_en(pix_en),
        .hpos(hpos),
        .vpos(vpos),
        .display_on(display_on),
        .border(border),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_data(mem_data),
        .red(red),
        .green(green),
        .blue(blue),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mdata(input logic [15:0] a);
        if (a == 16'h4000) return 8'h80;
        if (a == 16'h4001) return 8'h01;
        if (a == 16'h5800) return ATTR0;
        if (a[15:8] == 8'h58) return 8'h0A;
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic trig(input logic [9:0] v);
        pix_en = 1'b1;
        hpos   = 10'd0;
        vpos   = v;
        tick();
        pix_en = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 16'(mem_req), 16'd1);
    endtask

    task automatic serve(input logic [15:0] exp, input string tag);
        wait_req(tag);
        check(tag, mem_addr, exp);
        tick();
        tick();
        mem_ack  = 1'b1;
        mem_data = mdata(exp);
        tick();
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        check({tag, "_drop"}, 16'(mem_req), 16'd0);
    endtask

    task automatic px(input string tag, input logic [9:0] h, input logic [9:0] v,
                      input logic d, input logic [11:0] exp);
        pix_en     = 1'b1;
        hpos       = h;
        vpos       = v;
        display_on = d;
        tick();
        pix_en     = 1'b0;
        check(tag, 16'({red, green, blue}), 16'(exp));
    endtask

    initial begin
        reset      = 1'b1;
        pix_en     = 1'b0;
        hpos       = 10'd5;
        vpos       = 10'd5;
        display_on = 1'b0;
        border     = 3'b010;
        mem_ack    = 1'b0;
        mem_data   = 8'h00;
        repeat (3) tick();
        check("rst_req", 16'(mem_req), 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_rgb", 16'({red, green, blue}), 16'h0000);
        check("rst_underrun", 16'(underrun), 16'd0);
        reset = 1'b0;
        tick();

        // Start row 0, then overrun it with the row 9 trigger while in ATTR.
        trig(10'd524);
        serve(16'h4000, "ov_b0");
        wait_req("ov_a0");
        check("ov_a0_addr", mem_addr, 16'h5800);
        check("ov_pre", 16'(underrun), 16'd0);
        trig(10'd17);
        check("ov_abort_req", 16'(mem_req), 16'd0);
        check("ov_underrun", 16'(underrun), 16'd1);
        serve(16'h4120, "r9_b0");
        wait_req("r9_a0");
        check("r9_a0_addr", mem_addr, 16'h5820);
        repeat (5) tick();
        check("hold_req", 16'(mem_req), 16'd1);
        check("hold_addr", mem_addr, 16'h5820);
        check("sticky", 16'(underrun), 16'd1);
        px("border_r", 10'd600, 10'd400, 1'b1, 12'hA00);

        // Asynchronous reset in the middle of ATTR.
        #2;
        reset = 1'b1;
        #1;
        check("arst_req", 16'(mem_req), 16'd0);
        check("arst_addr", mem_addr, 16'h0000);
        check("arst_rgb", 16'({red, green, blue}), 16'h0000);
        check("arst_underrun", 16'(underrun), 16'd0);
        tick();
        reset = 1'b0;
        tick();

        trig(10'd524);
        for (int c = 0; c < 32; c++) begin
            serve(16'h4000 + 16'(c), $sformatf("f_b%0d", c));
            serve(16'h5800 + 16'(c), $sformatf("f_a%0d", c));
        end
        repeat (10) tick();
        check("idle_req", 16'(mem_req), 16'd0);
        check("idle_underrun", 16'(underrun), 16'd0);

        border = 3'b101;
        px("p_h0", 10'd0, 10'd0, 1'b1, 12'hFFF);
        px("p_h1", 10'd1, 10'd0, 1'b1, 12'hFFF);
        px("p_h2", 10'd2, 10'd0, 1'b1, 12'h000);
        px("p_h15", 10'd15, 10'd0, 1'b1, 12'h000);
        px("p_h16", 10'd16, 10'd0, 1'b1, 12'h00A);
        px("p_h30", 10'd30, 10'd0, 1'b1, 12'hA00);
        px("p_v1_h31", 10'd31, 10'd1, 1'b1, 12'hA00);
        px("p_h511", 10'd511, 10'd380, 1'b1, 12'h00A);
        px("b_h512", 10'd512, 10'd0, 1'b1, 12'h0AA);
        px("b_v384", 10'd100, 10'd384, 1'b1, 12'h0AA);
        px("blank", 10'd5, 10'd0, 1'b0, 12'h000);
        border = 3'b010;
        px("border_r2", 10'd600, 10'd100, 1'b1, 12'hA00);
        px("blank2", 10'd600, 10'd100, 1'b0, 12'h000);

`ifdef ZX_FLASH_EN
        // One frame tick so far; 15 more bring the counter to 16.
        for (int f = 0; f < 15; f++) begin
            px($sformatf("fl_tick%0d", f), 10'd0, 10'd0, 1'b1, 12'hFFF);
        end
        px("flash_ink", 10'd1, 10'd0, 1'b1, 12'h000);
        px("flash_paper", 10'd2, 10'd0, 1'b1, 12'hFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zx_pixel_fetch.md
Name: zx_pixel_fetch

Overview:
- Fetches ZX Spectrum screen memory (6144 bitmap bytes, 768 attribute bytes) through a req/ack memory port.
- Stores one character row per ZX line in a ping-pong line buffer.
- Renders 2x-scaled 512x384 RGB444 pixels, plus the border, from hpos/vpos supplied by hvsync_generator.
- Sits between the SDRAM arbiter (upstream) and the VGA RED/GREEN/BLUE pins (downstream).

Parameters:
- BASE, 16'h4000, byte address of screen memory in the memory port space.
- V_TOTAL, 525, total VGA lines per frame; row-0 prefetch runs on line V_TOTAL-1.
- ACTIVE_W, 512, width of the scaled paper area in VGA pixels.
- ACTIVE_H, 384, height of the scaled paper area in VGA lines.

Ports:
- clk  in  1  single block clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel clock enable; hpos/vpos/display_on are valid and advance on cycles where this is high.
- hpos  in  10  horizontal position from hvsync_generator.
- vpos  in  10  vertical position from hvsync_generator.
- display_on  in  1  visible-area flag from hvsync_generator.
- border  in  3  ZX border colour {G,R,B}.
- mem_req  out  1  read request.
- mem_addr  out  16  read byte address.
- mem_ack  in  1  one-cycle acknowledge; mem_data is valid in the same cycle.
- mem_data  in  8  read data.
- red, green, blue  out  4 each  pixel colour.
- underrun  out  1  sticky flag: a line fill did not complete in time.

Behaviour:
- Reset (asynchronous): mem_req=0, mem_addr=0, red/green/blue=0, underrun=0, FSM=IDLE, frame counter=0. Line buffer contents are don't-care.
- Line buffer: two banks, each 32 bitmap bytes + 32 attribute bytes. ZX row r (0..191) is displayed on VGA lines 2r and 2r+1 from bank r[0].
- Fill trigger (pix_en and hpos==0):
  - vpos==V_TOTAL-1: fill row 0.
  - vpos==2r+1 for r<191: fill row r+1 into bank (r+1)[0].
  - No other line triggers a fill.
- Fill addresses, for col 0..31, with y = ZX row:
  - bitmap = BASE + {y[7:6], y[2:0], y[5:3], col[4:0]}
  - attribute = BASE + 6144 + {y[7:3], col[4:0]}
- Fill FSM states: IDLE -> BMP -> ATTR -> (col==31 ? IDLE : BMP, col+1).
  - In BMP/ATTR, mem_req=1 and mem_addr is held stable until mem_ack.
  - On mem_ack the byte is written to the fill bank, and mem_req drops for at least one cycle before the next request.
  - Exactly 64 requests per fill, in the order B0, A0, B1, A1, ..., B31, A31.
  - mem_ack while mem_req=0 is ignored.
- Overrun: if a fill trigger arrives while the FSM is not IDLE:
  - set underrun (cleared only by reset);
  - abort the current fill (mem_req drops that cycle);
  - start the new fill.
  - Already-filled bytes of the aborted bank are kept.
- Rendering: registered outputs, updated only on pix_en; colour reflects the hpos/vpos sampled in that pix_en cycle (1-cycle latency).
  - display_on=0: RGB=0.
  - hpos<ACTIVE_W and vpos<ACTIVE_H (paper area):
    - col=hpos[8:4], bit index i=hpos[3:1].
    - pix = bitmap[col][7-i].
    - attr: [7] flash, [6] bright, [5:3] paper, [2:0] ink.
    - Colour = pix ? ink : paper.
  - Otherwise: border colour, never bright.
- Colour mapping: ZX colour c{G,R,B} gives green=c[2], red=c[1], blue=c[0] per channel.
  - Channel on: 4'hA, or 4'hF when bright.
  - Channel off: 4'h0.
- Frame counter: 5 bits, increments on the pix_en cycle with hpos==0 and vpos==0, wraps 31->0.

Optional Feature:
- Macro ZX_FLASH_EN.
- Defined: when attr[7]=1 and frame_cnt[4]=1, ink and paper are swapped (ZX flash at 16-frame half period).
- Undefined: attr[7] is ignored and the frame counter is not built.

Test Plan:
1. Reset mid-fill (mem_req=1, FSM in ATTR): assert reset -> same cycle mem_req=0, RGB=0, underrun=0; next fill begins at the next trigger with address BASE.
2. Row 0 fill on vpos=524, hpos=0, mem_ack 3 cycles after each req -> 64 requests: 16'h4000, 16'h5800, 16'h4001, 16'h5801, ..., 16'h401F, 16'h581F; FSM then IDLE.
3. Row 9 fill (trigger at vpos=17) -> first two addresses 16'h4120 (bitmap) and 16'h5820 (attribute).
4. Row 0 bitmap[0]=8'h80, attr[0]=8'h47 (bright, paper 0, ink 7), vpos=0 -> hpos 0,1 render RGB=F/F/F; hpos 2..15 render RGB=0/0/0.
5. Outside paper with display_on=1, hpos=600, border=3'b010 -> red=A, green=0, blue=0; with display_on=0 -> all 0.
6. Withhold mem_ack across the next trigger -> underrun=1 and stays 1; a new fill starts at bitmap col 0 of the new row. With ZX_FLASH_EN and attr=8'hC7, frames 16..31 -> ink/paper swapped.
